// File: rtl/tx_channel_if.sv
// tx_channel_if: VALID/READY data channel between a sender (master) and a receiver (slave)
interface tx_channel_if #(
  parameter int WIDTH = 8
);
  logic             VALID;
  logic             READY;
  logic [WIDTH-1:0] xDATA;
  modport master (output VALID, output xDATA, input READY);
  modport slave  (input VALID, input xDATA, output READY);
endinterface

// File: rtl/tx_channel.sv
// tx_channel: transmit side of a VALID/READY channel with a two-entry (output + skid) buffer
module tx_channel #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  tx_channel_if.master      bus,
  input  logic [WIDTH-1:0]  tx_data,
  input  logic              tx_load,
  output logic              tx_full,
  output logic              tx_done,
  output logic [CNT_W-1:0]  tx_count
);
  typedef enum logic [1:0] {RST, EMPTY, ONE, FULL} state_t;
  state_t           st;
  logic             valid_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] skid_q;
  logic             fire;
  logic             ld;
  assign fire      = valid_q && bus.READY;
  assign ld        = tx_load && !tx_full;
  assign bus.VALID = valid_q;
  assign bus.xDATA = out_q;
  // Buffer FSM: VALID and tx_full are registered alongside the state so neither depends on READY
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      st       <= RST;
      valid_q  <= 1'b0;
      tx_full  <= 1'b1;
      out_q    <= '0;
      skid_q   <= '0;
      tx_done  <= 1'b0;
      tx_count <= '0;
    end else begin
      tx_done  <= fire;
      tx_count <= tx_count + CNT_W'(fire);
      case (st)
        RST: begin
          st      <= EMPTY;
          tx_full <= 1'b0;
        end
        EMPTY: if (ld) begin
          out_q   <= tx_data;
          valid_q <= 1'b1;
          st      <= ONE;
        end
        ONE: begin
          if (fire && ld) out_q <= tx_data;
          else if (fire) begin
            valid_q <= 1'b0;
            st      <= EMPTY;
          end else if (ld) begin
            skid_q  <= tx_data;
            tx_full <= 1'b1;
            st      <= FULL;
          end
        end
        FULL: if (fire) begin
          out_q   <= skid_q;
          tx_full <= 1'b0;
          st      <= ONE;
        end
      endcase
    end
  end
endmodule

// File: doc/tx_channel.md
# tx_channel

Transmit side of a single AXI-style VALID/READY channel. It is the sending counterpart of the receive channel block: the upper module loads words, and this block presents them on the bus and holds them stable until the receiver accepts. A two-entry buffer (output register plus skid register) sustains one beat per clock while READY stays high. It also absorbs one extra load while the bus is stalled.

## Interface
Parameters:
- WIDTH, 8, data width of the bus and the load port
- CNT_W, 16, width of the sent-beat counter

Ports:
- ACLK  input  1  single clock; all state updates on rising edge
- ARESETn  input  1  asynchronous, active-low reset
- VALID  output  1  bus VALID, driven from a register; never depends combinationally on READY
- READY  input  1  bus READY from the receiver
- xDATA  output  WIDTH  bus data, driven from the output register
- tx_data  input  WIDTH  word from the upper module
- tx_load  input  1  upper module requests that tx_data be queued this cycle
- tx_full  output  1  high when a load would be refused; a tx_load while tx_full is high is ignored
- tx_done  output  1  one-cycle pulse, registered, the cycle after a handshake completes
- tx_count  output  CNT_W  number of completed handshakes, wraps modulo 2^CNT_W

## Operation
- Handshake: fire = VALID && READY, sampled at the rising edge of ACLK. Load: ld = tx_load && !tx_full.
- Storage: out_q drives xDATA, and skid_q holds the second word.
- States: RST, EMPTY, ONE, FULL.
  - VALID = (state == ONE || state == FULL).
  - tx_full = (state == RST || state == FULL).
- RST: entered on reset. VALID is 0 and tx_full is 1. It moves unconditionally to EMPTY at the first clock edge after ARESETn deasserts.
- EMPTY:
  - ld: out_q <= tx_data, go to ONE.
  - Otherwise stay in EMPTY.
- ONE:
  - fire && ld: out_q <= tx_data, stay in ONE (back-to-back streaming).
  - fire && !ld: go to EMPTY. out_q keeps its old value; xDATA is don't-care while VALID = 0.
  - !fire && ld: skid_q <= tx_data, go to FULL. out_q is unchanged.
  - Neither: stay in ONE, with out_q stable.
- FULL: tx_load is ignored.
  - fire: out_q <= skid_q, go to ONE.
  - Otherwise stay in FULL, with out_q and skid_q stable.
- Protocol rules the block guarantees:
  - Once VALID rises, it stays high and xDATA stays unchanged until an edge with READY = 1.
  - VALID is never withdrawn without a handshake.
  - VALID is low during reset and during RST.
- tx_done <= fire. tx_count <= tx_count + fire, and wraps from 2^CNT_W-1 to 0.
- Words leave the block in the order they were loaded. No word is dropped or duplicated except on reset.

## Timing
- Reset values, asserted asynchronously on ARESETn falling:
  - state = RST, VALID = 0, tx_full = 1, tx_done = 0
  - tx_count = 0, xDATA = 0, skid_q = 0
- Reset mid-operation: buffered words are discarded. VALID drops immediately, without waiting for a clock edge.
- Load-to-bus latency: a load at edge N makes VALID = 1 and xDATA = that word visible after edge N, i.e. in cycle N+1.
- Throughput: 1 beat per cycle when tx_load and READY are both held high continuously from ONE.
- tx_full rises in the cycle after the edge that fills skid_q. It falls in the cycle after the edge on which fire occurs in FULL.
- Simultaneous events:
  - In FULL, fire together with tx_load = 1: the load is refused, because tx_full was 1 at that edge.
  - In ONE, fire together with ld: both take effect at the same edge.
- READY may be high while VALID is low; nothing happens.
- tx_done goes high in the cycle after the fire edge, lasts exactly 1 cycle per beat, and is high continuously during streaming.

## Test plan
- Reset: hold ARESETn = 0 with random inputs -> VALID = 0, tx_full = 1, tx_count = 0, xDATA = 0. After release, tx_full = 0 one edge later.
- Single beat: load 0xA5 with READY = 0 for 3 cycles, then READY = 1 -> VALID high and xDATA = 0xA5, stable for all 3 stall cycles. One tx_done pulse follows, tx_count = 1, and the block returns to VALID = 0.
- Stall and fill: with READY = 0, load 0x11, 0x22, 0x33 on consecutive cycles -> tx_full = 1 after the second load, and 0x33 is ignored. Then with READY = 1, the bus shows 0x11 then 0x22, and tx_count = 2.
- Streaming: READY = 1, load 0x00..0x0F on 16 consecutive cycles -> the same 16 values on xDATA in order, one per cycle. tx_done is high for 16 cycles and tx_count = 16.
- Wrap: CNT_W = 4, 17 handshakes -> tx_count reads 1.
- Reset mid-operation: in FULL with VALID = 1, pulse ARESETn low between edges -> VALID falls immediately. After release, no stale word appears and the next loaded word (0x5A) is the first one sent.
